instr_fetch: RTL and testbench



---
 rtl/fetch_pkg.sv | 11 +
 rtl/instr_fetch_if.sv | 31 +++
 rtl/instr_fetch_sat_counter.sv | 15 +
 rtl/instr_fetch.sv | 64 ++++++
 tb/tb_instr_fetch.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and instruction field positions for instr_fetch.
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALTED} state_t;
  localparam int OPC_MSB = 8;
  localparam int OPC_LSB = 6;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 3;
  localparam logic [2:0] OP_BRANCH = 3'b010;
  localparam logic [2:0] FN_BR = 3'b000;
  localparam logic [2:0] FN_BEZ = 3'b001;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: ROM, Control and host-side signals of the fetch unit.
interface instr_fetch_if #(
  parameter int PC_W = 10,
  parameter int INSTR_W = 9,
  parameter int CNT_W = 16
);
  logic start;
  logic [PC_W-1:0] start_addr;
  logic [PC_W-1:0] instr_addr;
  logic [INSTR_W-1:0] instr_data;
  logic [2:0] opcode;
  logic [2:0] funct;
  logic instr_valid;
  logic branch;
  logic branch_cond;
  logic halt;
  logic zero;
  logic [PC_W-1:0] branch_target;
  logic [PC_W-1:0] pc;
  logic done;
  logic [CNT_W-1:0] instr_count;
  logic [CNT_W-1:0] cycle_count;
  modport master (
    input start, start_addr, instr_data, branch, branch_cond, halt, zero, branch_target,
    output instr_addr, opcode, funct, instr_valid, pc, done, instr_count, cycle_count
  );
  modport slave (
    output start, start_addr, instr_data, branch, branch_cond, halt, zero, branch_target,
    input instr_addr, opcode, funct, instr_valid, pc, done, instr_count, cycle_count
  );
endinterface

// File: rtl/instr_fetch_sat_counter.sv
// sat_counter: counter that sticks at all-ones; clear has priority over enable.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (clr) q <= '0;
    else if (en && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC owner and two-cycle FETCH/EXEC sequencer feeding Control.
module instr_fetch import fetch_pkg::*; #(
  parameter int PC_W = 10,
  parameter int INSTR_W = 9,
  parameter int CNT_W = 16
) (
  input logic           clk,
  input logic           rst_n,
  instr_fetch_if.master bus
);
  state_t state, state_n;
  logic [PC_W-1:0] pc, pc_n;
  logic [INSTR_W-1:0] instr;
  logic done, done_n, accept, taken, in_exec, unused_bits;
  assign instr = bus.instr_data;
  assign in_exec = state == EXEC;
  assign accept = (state == IDLE || state == HALTED) && bus.start;
  assign taken = bus.branch && (!bus.branch_cond || bus.zero);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pc <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      done <= done_n;
    end
  // Control outputs only matter in EXEC, so halt/branch are never looked at elsewhere.
  always_comb begin
    state_n = state;
    pc_n = pc;
    done_n = done;
    case (state)
      IDLE, HALTED: if (bus.start) begin
        state_n = FETCH;
        pc_n = bus.start_addr;
        done_n = 1'b0;
      end
      FETCH: state_n = EXEC;
      EXEC: if (bus.halt) begin
        state_n = HALTED;
        done_n = 1'b1;
      end else begin
        state_n = FETCH;
        pc_n = taken ? bus.branch_target : pc + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  assign bus.pc = pc;
  assign bus.instr_addr = pc;
  assign bus.done = done;
  assign bus.instr_valid = in_exec;
  assign bus.opcode = in_exec ? instr[OPC_MSB:OPC_LSB] : 3'b000;
  assign bus.funct = in_exec ? instr[FUNCT_MSB:FUNCT_LSB] : 3'b000;
  assign unused_bits = ^instr[FUNCT_LSB-1:0];
  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk(clk), .rst_n(rst_n), .en(in_exec), .clr(accept), .q(bus.instr_count)
  );
  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk(clk), .rst_n(rst_n), .en(state == FETCH || in_exec), .clr(accept), .q(bus.cycle_count)
  );
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: table vectors, hand sequences and a random program run against a PC model.
module tb_instr_fetch;
  import fetch_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  instr_fetch_if fi ();
  instr_fetch_if #(.CNT_W(4)) fs ();
  instr_fetch dut (.clk(clk), .rst_n(rst_n), .bus(fi.master));
  instr_fetch #(.CNT_W(4)) dut_small (.clk(clk), .rst_n(rst_n), .bus(fs.master));
  logic [8:0] rom [1024];
  always @(posedge clk) begin
    fi.instr_data <= rom[fi.instr_addr];
    fs.instr_data <= rom[fs.instr_addr];
  end
  typedef struct {
    logic [9:0] sa;
    logic [8:0] ins;
    logic br, bc, z, h;
    logic [9:0] tgt;
    logic [9:0] exp_pc;
    logic exp_done;
  } vec_t;
  vec_t tbl [9];
  int vectors = 0;
  int miscompares = 0;
  logic [8:0] w;
  logic [9:0] exp_pc;
  int ic, cc;
  logic r_br, r_bc, r_z, r_h;
  logic [9:0] r_tgt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctl(input logic br, input logic bc, input logic z, input logic h, input logic [9:0] tgt);
    fi.branch = br;
    fi.branch_cond = bc;
    fi.zero = z;
    fi.halt = h;
    fi.branch_target = tgt;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fi.start = 1'b0;
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic start_at(input logic [9:0] a);
    fi.start = 1'b1;
    fi.start_addr = a;
    tick();
    fi.start = 1'b0;
  endtask

  // Called in FETCH; leaves the unit in the following FETCH (or HALTED).
  task automatic run1(input logic br, input logic bc, input logic z, input logic h, input logic [9:0] tgt);
    tick();
    set_ctl(br, bc, z, h, tgt);
    tick();
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
  endtask

  initial begin
    fi.start = 1'b0;
    fi.start_addr = '0;
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
    fs.start = 1'b0;
    fs.start_addr = '0;
    fs.branch = 1'b0;
    fs.branch_cond = 1'b0;
    fs.zero = 1'b0;
    fs.halt = 1'b0;
    fs.branch_target = '0;
    for (int i = 0; i < 1024; i++) rom[i] = 9'd0;
    tbl[0] = '{10'd5,    9'b011_000_000, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   10'd6,   1'b0};
    tbl[1] = '{10'd6,    9'b010_000_000, 1'b1, 1'b0, 1'b0, 1'b0, 10'd20,  10'd20,  1'b0};
    tbl[2] = '{10'd20,   9'b010_001_000, 1'b1, 1'b1, 1'b0, 1'b0, 10'd40,  10'd21,  1'b0};
    tbl[3] = '{10'd20,   9'b010_001_000, 1'b1, 1'b1, 1'b1, 1'b0, 10'd40,  10'd40,  1'b0};
    tbl[4] = '{10'd40,   9'b111_000_000, 1'b1, 1'b0, 1'b0, 1'b1, 10'd99,  10'd40,  1'b1};
    tbl[5] = '{10'd1023, 9'b011_010_000, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   10'd0,   1'b0};
    tbl[6] = '{10'd1023, 9'b010_001_000, 1'b1, 1'b1, 1'b1, 1'b0, 10'd7,   10'd7,   1'b0};
    tbl[7] = '{10'd300,  9'b010_000_000, 1'b1, 1'b0, 1'b1, 1'b0, 10'd512, 10'd512, 1'b0};
    tbl[8] = '{10'd0,    9'b111_111_111, 1'b0, 1'b1, 1'b1, 1'b0, 10'd9,   10'd1,   1'b0};

    do_reset();
    chk("reset_pc", fi.pc, 0);
    chk("reset_addr", fi.instr_addr, 0);
    chk("reset_valid", fi.instr_valid, 0);
    chk("reset_opcode", fi.opcode, 0);
    chk("reset_done", fi.done, 0);
    chk("reset_icount", fi.instr_count, 0);
    chk("reset_ccount", fi.cycle_count, 0);

    for (int i = 0; i < 9; i++) begin
      do_reset();
      rom[tbl[i].sa] = tbl[i].ins;
      w = tbl[i].ins;
      start_at(tbl[i].sa);
      chk("tbl_fetch_addr", fi.instr_addr, tbl[i].sa);
      chk("tbl_fetch_valid", fi.instr_valid, 0);
      chk("tbl_fetch_opcode", fi.opcode, 0);
      tick();
      chk("tbl_exec_valid", fi.instr_valid, 1);
      chk("tbl_exec_opcode", fi.opcode, w[8:6]);
      chk("tbl_exec_funct", fi.funct, w[5:3]);
      set_ctl(tbl[i].br, tbl[i].bc, tbl[i].z, tbl[i].h, tbl[i].tgt);
      tick();
      set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
      chk("tbl_pc", fi.pc, tbl[i].exp_pc);
      chk("tbl_addr", fi.instr_addr, tbl[i].exp_pc);
      chk("tbl_done", fi.done, tbl[i].exp_done);
      chk("tbl_icount", fi.instr_count, 1);
      chk("tbl_ccount", fi.cycle_count, 2);
    end

    // Chained program ending in halt, then restart and ignored-input checks.
    do_reset();
    rom[5] = 9'b011_000_000;
    rom[6] = 9'b010_000_000;
    rom[20] = 9'b010_001_000;
    rom[21] = 9'b010_001_000;
    rom[40] = 9'b111_000_000;
    rom[0] = 9'b001_000_000;
    rom[1] = 9'b101_110_000;
    start_at(10'd5);
    run1(1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
    chk("seq_pc_add", fi.pc, 6);
    chk("seq_icount1", fi.instr_count, 1);
    chk("seq_ccount1", fi.cycle_count, 2);
    run1(1'b1, 1'b0, 1'b0, 1'b0, 10'd20);
    chk("seq_pc_br", fi.pc, 20);
    chk("seq_addr_br", fi.instr_addr, 20);
    run1(1'b1, 1'b1, 1'b0, 1'b0, 10'd40);
    chk("seq_pc_bez_nt", fi.pc, 21);
    run1(1'b1, 1'b1, 1'b1, 1'b0, 10'd40);
    chk("seq_pc_bez_t", fi.pc, 40);
    run1(1'b1, 1'b0, 1'b0, 1'b1, 10'd77);
    chk("seq_halt_done", fi.done, 1);
    chk("seq_halt_pc", fi.pc, 40);
    chk("seq_halt_valid", fi.instr_valid, 0);
    chk("seq_halt_icount", fi.instr_count, 5);
    chk("seq_halt_ccount", fi.cycle_count, 10);
    tick();
    tick();
    chk("seq_hold_pc", fi.pc, 40);
    chk("seq_hold_valid", fi.instr_valid, 0);
    chk("seq_hold_done", fi.done, 1);
    chk("seq_hold_ccount", fi.cycle_count, 10);
    start_at(10'd0);
    chk("seq_restart_done", fi.done, 0);
    chk("seq_restart_icount", fi.instr_count, 0);
    chk("seq_restart_ccount", fi.cycle_count, 0);
    chk("seq_restart_addr", fi.instr_addr, 0);
    fi.start = 1'b1;
    fi.start_addr = 10'd99;
    set_ctl(1'b1, 1'b0, 1'b0, 1'b1, 10'd55);
    tick();
    chk("seq_ign_valid", fi.instr_valid, 1);
    chk("seq_ign_opcode", fi.opcode, 1);
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
    tick();
    fi.start = 1'b0;
    chk("seq_ign_pc", fi.pc, 1);
    chk("seq_ign_done", fi.done, 0);
    chk("seq_ign_icount", fi.instr_count, 1);
    chk("seq_ign_ccount", fi.cycle_count, 2);

    // Asynchronous reset in the middle of EXEC.
    tick();
    chk("arst_pre_opcode", fi.opcode, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pc", fi.pc, 0);
    chk("arst_addr", fi.instr_addr, 0);
    chk("arst_valid", fi.instr_valid, 0);
    chk("arst_opcode", fi.opcode, 0);
    chk("arst_funct", fi.funct, 0);
    chk("arst_done", fi.done, 0);
    chk("arst_icount", fi.instr_count, 0);
    chk("arst_ccount", fi.cycle_count, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_idle_pc", fi.pc, 0);
    chk("arst_idle_valid", fi.instr_valid, 0);

    // Saturation on the narrow-counter instance.
    fs.start = 1'b1;
    fs.start_addr = 10'd100;
    tick();
    fs.start = 1'b0;
    repeat (14) tick();
    chk("sat_ccount_14", fs.cycle_count, 14);
    chk("sat_icount_7", fs.instr_count, 7);
    repeat (26) tick();
    chk("sat_ccount_max", fs.cycle_count, 15);
    chk("sat_icount_max", fs.instr_count, 15);

    // Random program against the PC/counter model.
    do_reset();
    for (int i = 0; i < 1024; i++) rom[i] = 9'($urandom);
    exp_pc = 10'($urandom_range(0, 1023));
    ic = 0;
    cc = 0;
    start_at(exp_pc);
    for (int n = 0; n < 300; n++) begin
      chk("rnd_fetch_addr", fi.instr_addr, exp_pc);
      chk("rnd_fetch_valid", fi.instr_valid, 0);
      set_ctl(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 10'($urandom));
      fi.start = 1'($urandom);
      fi.start_addr = 10'($urandom);
      tick();
      fi.start = 1'b0;
      w = rom[exp_pc];
      chk("rnd_exec_opcode", fi.opcode, w[8:6]);
      chk("rnd_exec_funct", fi.funct, w[5:3]);
      r_br = 1'($urandom);
      r_bc = 1'($urandom);
      r_z = 1'($urandom);
      r_h = $urandom_range(0, 15) == 0;
      r_tgt = 10'($urandom);
      set_ctl(r_br, r_bc, r_z, r_h, r_tgt);
      tick();
      set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
      ic = ic + 1 > 65535 ? 65535 : ic + 1;
      cc = cc + 2 > 65535 ? 65535 : cc + 2;
      chk("rnd_icount", fi.instr_count, ic);
      chk("rnd_ccount", fi.cycle_count, cc);
      if (r_h) begin
        chk("rnd_halt_done", fi.done, 1);
        chk("rnd_halt_pc", fi.pc, exp_pc);
        repeat ($urandom_range(0, 3)) tick();
        chk("rnd_halt_hold", fi.pc, exp_pc);
        exp_pc = 10'($urandom);
        ic = 0;
        cc = 0;
        start_at(exp_pc);
        chk("rnd_restart_done", fi.done, 0);
      end else begin
        exp_pc = (r_br && (!r_bc || r_z)) ? r_tgt : 10'((int'(exp_pc) + 1) % 1024);
        chk("rnd_pc", fi.pc, exp_pc);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
